agen_addr_stage: RTL and testbench
==================================

// Module: agen_addr_stage
// PURPOSE
//  Address-generation stage of the load/store execute pipe; sits directly upstream of the AGEN->LSU pipeline register.
//  Computes effective address = src1 + sign-extended imm and flags misaligned accesses.
//  Presents one memory op per cycle to the LSU-side register over a valid/ready handshake.
//  A one-entry skid buffer absorbs LSU backpressure without dropping ops or reordering them.
// PARAMETERS
//  ADDR_WIDTH    64  effective-address and src1 width
//  IMM_WIDTH     12  immediate width, sign-extended to ADDR_WIDTH
//  LSQ_ID_WIDTH   5  load/store queue index width
//  PHY_REG_WIDTH  7  physical destination register tag width
// PORTS
//  clk           in   1              clock; all state updates on posedge
//  reset         in   1              synchronous, active-high reset
//  flush_i       in   1              pipeline flush; drops all held and incoming ops
//  valid_i       in   1              issued memory op present
//  ready_o       out  1              stage can accept an op this cycle
//  src1_i        in   ADDR_WIDTH     base register value
//  imm_i         in   IMM_WIDTH      offset immediate
//  ldstSize_i    in   2              0=byte 1=half 2=word 3=dword
//  isLoad_i      in   1              1=load, 0=store
//  lsqId_i       in   LSQ_ID_WIDTH   LSQ entry of the op
//  phyDest_i     in   PHY_REG_WIDTH  load destination tag (don't-care for stores)
//  valid_o       out  1              op available to downstream
//  ready_i       in   1              downstream accepts op this cycle
//  address_o     out  ADDR_WIDTH     effective address
//  ldstSize_o    out  2              passed-through size
//  isLoad_o      out  1              passed-through load flag
//  lsqId_o       out  LSQ_ID_WIDTH   passed-through LSQ index
//  phyDest_o     out  PHY_REG_WIDTH  passed-through destination tag
//  misaligned_o  out  1              address not naturally aligned for size
//  misalignCnt_o out  16             saturating count of misaligned ops delivered
// BEHAVIOUR
//  - Reset: every output 0 except ready_o=1; skid buffer invalid; counter 0.
//  - Transfer in: valid_i & ready_o. Transfer out: valid_o & ready_i.
//  - ready_o = ~skidValid (registered state only; no comb path from ready_i).
//  - Address: addr = src1_i + {{(ADDR_WIDTH-IMM_WIDTH){imm_i[MSB]}},imm_i}, mod 2^ADDR_WIDTH (wrap, no carry-out).
//  - Misaligned: size1 & addr[0]; size2 & |addr[1:0]; size3 & |addr[2:0]; size0 never. Computed at input, carried with op.
//  - Latency: 1 cycle input->output when not stalled; throughput 1 op/cycle while ready_i=1.
//  - States (outValid,skidValid): EMPTY(0,0), ONE(1,0), FULL(1,1). (0,1) unreachable.
//    EMPTY: in -> ONE (op loads output reg).
//    ONE: in & out -> ONE (new op replaces output); in & ~out -> FULL (new op to skid);
//         ~in & out -> EMPTY; ~in & ~out -> ONE (hold).
//    FULL: ready_o=0; out -> ONE (skid moves to output); ~out -> FULL (hold both).
//  - Output fields stable while valid_o=1 and ready_i=0. Order strictly FIFO.
//  - flush_i (higher priority than all handshakes): next cycle outValid=skidValid=0, ready_o=1;
//    op presented on flush cycle is dropped; counter not changed by flush; transfer-out on flush cycle still counts.
//  - Counter: +1 on transfer out with misaligned_o=1; saturates at 16'hFFFF; cleared only by reset.
//  - reset mid-operation: same as power-up reset, overrides flush_i and handshakes.
// TESTING
//  - Stream: src1=0x1000, imm=0xFFC (-4), size=2, ready_i=1 -> next cycle valid_o=1, address_o=0xFFC, misaligned_o=0; back-to-back ops 1/cycle.
//  - Backpressure: 3 ops issued with ready_i=0 -> op0 on output, op1 in skid, ready_o=0 after 2nd accept; op2 held upstream; release ready_i -> op0,op1,op2 in order, no gaps after release.
//  - Misalign: size=3, src1=0x2004, imm=0 -> misaligned_o=1, misalignCnt_o 0->1 only on the cycle ready_i=1; size=0 any addr -> 0.
//  - Wrap: src1=0xFFFF_FFFF_FFFF_FFFF, imm=1 -> address_o=0; src1=0, imm=0x800 -> address_o=0xFFFF_FFFF_FFFF_F800.
//  - Flush in FULL state with valid_i=1 -> next cycle valid_o=0, ready_o=1, counter unchanged; no flushed op ever appears.
//  - Counter saturation: preload via 65535 misaligned deliveries -> 16'hFFFF stays after further misaligned op; reset -> 0, ready_o=1.

Source files
------------

// File: rtl/agen_addr_stage.sv
// Address-generation stage: effective address = src1 + sext(imm), misalignment
// detection, and a one-entry skid buffer in front of the AGEN->LSU register.
module agen_addr_stage #(
  parameter int ADDR_WIDTH    = 64,
  parameter int IMM_WIDTH     = 12,
  parameter int LSQ_ID_WIDTH  = 5,
  parameter int PHY_REG_WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [ADDR_WIDTH-1:0]    src1_i,
  input  logic [IMM_WIDTH-1:0]     imm_i,
  input  logic [1:0]               ldstSize_i,
  input  logic                     isLoad_i,
  input  logic [LSQ_ID_WIDTH-1:0]  lsqId_i,
  input  logic [PHY_REG_WIDTH-1:0] phyDest_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [ADDR_WIDTH-1:0]    address_o,
  output logic [1:0]               ldstSize_o,
  output logic                     isLoad_o,
  output logic [LSQ_ID_WIDTH-1:0]  lsqId_o,
  output logic [PHY_REG_WIDTH-1:0] phyDest_o,
  output logic                     misaligned_o,
  output logic [15:0]              misalignCnt_o,
  output logic [1:0]               state_o
);

  // Handshake: an op moves across a port on a rising clk edge exactly when
  // that port's valid and ready are both 1. ready_o depends on registered
  // state only; valid_o/fields hold steady while valid_o=1 and ready_i=0.

  // State encoding is {out_valid, skid_valid}.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [1:0]               size;
    logic                     is_load;
    logic [LSQ_ID_WIDTH-1:0]  lsq_id;
    logic [PHY_REG_WIDTH-1:0] phy_dest;
    logic                     mis;
  } op_t;

  logic            out_valid;
  logic            skid_valid;
  op_t             out_q;
  op_t             skid_q;
  op_t             in_op;
  logic [15:0]     mis_cnt;
  logic [1:0]      state;
  logic            in_xfer;
  logic            out_xfer;

  logic [ADDR_WIDTH-1:0] imm_ext;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  in_mis;

  assign imm_ext = {{(ADDR_WIDTH-IMM_WIDTH){imm_i[IMM_WIDTH-1]}}, imm_i};
  assign in_addr = src1_i + imm_ext;

  always_comb begin
    in_mis = 1'b0;
    case (ldstSize_i)
      2'd1:    in_mis = in_addr[0];
      2'd2:    in_mis = |in_addr[1:0];
      2'd3:    in_mis = |in_addr[2:0];
      default: in_mis = 1'b0;
    endcase
  end

  always_comb begin
    in_op          = '0;
    in_op.addr     = in_addr;
    in_op.size     = ldstSize_i;
    in_op.is_load  = isLoad_i;
    in_op.lsq_id   = lsqId_i;
    in_op.phy_dest = phyDest_i;
    in_op.mis      = in_mis;
  end

  assign state    = {out_valid, skid_valid};
  assign ready_o  = ~skid_valid;
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = out_valid & ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      mis_cnt    <= '0;
    end else begin
      // A delivery on a flush cycle still happened downstream, so it counts.
      if (out_xfer && out_q.mis && (mis_cnt != 16'hFFFF))
        mis_cnt <= mis_cnt + 16'd1;

      if (flush_i) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (in_xfer) begin
              out_valid <= 1'b1;
              out_q     <= in_op;
            end
          end
          ST_ONE: begin
            if (in_xfer && out_xfer) begin
              out_q <= in_op;
            end else if (in_xfer) begin
              skid_valid <= 1'b1;
              skid_q     <= in_op;
            end else if (out_xfer) begin
              out_valid <= 1'b0;
            end
          end
          ST_FULL: begin
            if (out_xfer) begin
              out_q      <= skid_q;
              skid_valid <= 1'b0;
            end
          end
          default: begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign valid_o       = out_valid;
  assign address_o     = out_q.addr;
  assign ldstSize_o    = out_q.size;
  assign isLoad_o      = out_q.is_load;
  assign lsqId_o       = out_q.lsq_id;
  assign phyDest_o     = out_q.phy_dest;
  assign misaligned_o  = out_q.mis;
  assign misalignCnt_o = mis_cnt;
  assign state_o       = state;

endmodule

// File: tb/tb_agen_addr_stage.sv
// Bench for agen_addr_stage: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a 2-deep FIFO model.
module tb_agen_addr_stage;

  typedef struct packed {
    logic [63:0] addr;
    logic [1:0]  size;
    logic        ld;
    logic [4:0]  id;
    logic [6:0]  pd;
    logic        mis;
  } op_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [63:0] src1_i = '0;
  logic [11:0] imm_i = '0;
  logic [1:0]  ldstSize_i = '0;
  logic        isLoad_i = 1'b0;
  logic [4:0]  lsqId_i = '0;
  logic [6:0]  phyDest_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [63:0] address_o;
  logic [1:0]  ldstSize_o;
  logic        isLoad_o;
  logic [4:0]  lsqId_o;
  logic [6:0]  phyDest_o;
  logic        misaligned_o;
  logic [15:0] misalignCnt_o;
  logic [1:0]  state_o;

  agen_addr_stage dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .src1_i(src1_i), .imm_i(imm_i), .ldstSize_i(ldstSize_i), .isLoad_i(isLoad_i),
    .lsqId_i(lsqId_i), .phyDest_i(phyDest_i), .valid_o(valid_o), .ready_i(ready_i),
    .address_o(address_o), .ldstSize_o(ldstSize_o), .isLoad_o(isLoad_o),
    .lsqId_o(lsqId_o), .phyDest_o(phyDest_o), .misaligned_o(misaligned_o),
    .misalignCnt_o(misalignCnt_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: the stage behaves as a FIFO of capacity two
  op_t         exp_q[$];
  logic [15:0] m_cnt = '0;

  function automatic op_t make_op(input logic [63:0] s, input logic [11:0] im,
                                  input logic [1:0] sz, input logic ld,
                                  input logic [4:0] id, input logic [6:0] pd);
    op_t o;
    longint unsigned off;
    off = (im >= 12'd2048) ? (64'd0 - (64'd4096 - 64'(im))) : 64'(im);
    o.addr = s + off;
    o.size = sz;
    o.ld   = ld;
    o.id   = id;
    o.pd   = pd;
    o.mis  = (o.addr % (64'd1 << sz)) != 64'd0;
    return o;
  endfunction

  always @(posedge clk) begin
    bit in_x, out_x;
    if (reset) begin
      exp_q.delete();
      m_cnt = '0;
    end else begin
      in_x  = valid_i && (exp_q.size() < 2);
      out_x = (exp_q.size() > 0) && ready_i;
      if (out_x && exp_q[0].mis && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (flush_i) exp_q.delete();
      else begin
        if (out_x) void'(exp_q.pop_front());
        if (in_x) exp_q.push_back(make_op(src1_i, imm_i, ldstSize_i, isLoad_i, lsqId_i, phyDest_i));
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_o", 64'(ready_o), 64'(exp_q.size() < 2));
      chk("valid_o", 64'(valid_o), 64'(exp_q.size() > 0));
      chk("cnt", 64'(misalignCnt_o), 64'(m_cnt));
      chk("state_o", 64'(state_o), {62'd0, exp_q.size() > 0, exp_q.size() == 2});
      if (exp_q.size() > 0) begin
        chk("address_o", address_o, exp_q[0].addr);
        chk("size_o", 64'(ldstSize_o), 64'(exp_q[0].size));
        chk("isLoad_o", 64'(isLoad_o), 64'(exp_q[0].ld));
        chk("lsqId_o", 64'(lsqId_o), 64'(exp_q[0].id));
        chk("phyDest_o", 64'(phyDest_o), 64'(exp_q[0].pd));
        chk("misaligned_o", 64'(misaligned_o), 64'(exp_q[0].mis));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [63:0] s, input logic [11:0] im, input logic [1:0] sz,
                        input logic [4:0] id);
    valid_i    = 1'b1;
    src1_i     = s;
    imm_i      = im;
    ldstSize_i = sz;
    isLoad_i   = id[0];
    lsqId_i    = id;
    phyDest_i  = {2'b0, id};
  endtask

  initial begin
    int n;
    logic [15:0] cnt_before;

    reset = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst ready_o", 64'(ready_o), 64'd1);
    chk("rst valid_o", 64'(valid_o), 64'd0);
    chk("rst address_o", address_o, 64'd0);
    chk("rst misaligned_o", 64'(misaligned_o), 64'd0);
    chk("rst cnt", 64'(misalignCnt_o), 64'd0);
    reset = 1'b0;
    tick();

    // stream with ready_i=1
    ready_i = 1'b1;
    set_op(64'h1000, 12'hFFC, 2'd2, 5'd1);
    tick();
    chk("stream valid", 64'(valid_o), 64'd1);
    chk("stream addr", address_o, 64'hFFC);
    chk("stream mis", 64'(misaligned_o), 64'd0);
    set_op(64'h1000, 12'h010, 2'd2, 5'd2);
    tick();
    chk("stream b2b addr", address_o, 64'h1010);
    set_op(64'h1000, 12'h020, 2'd3, 5'd3);
    tick();
    chk("stream b2b2 addr", address_o, 64'h1020);
    chk("stream b2b2 id", 64'(lsqId_o), 64'd3);
    valid_i = 1'b0;
    tick();
    chk("stream drained", 64'(valid_o), 64'd0);

    // backpressure: op0 out, op1 in skid, op2 held upstream
    ready_i = 1'b0;
    set_op(64'h4000, 12'h000, 2'd2, 5'd10);
    tick();
    chk("bp op0 addr", address_o, 64'h4000);
    chk("bp ready after op0", 64'(ready_o), 64'd1);
    set_op(64'h4000, 12'h004, 2'd2, 5'd11);
    tick();
    chk("bp ready after op1", 64'(ready_o), 64'd0);
    chk("bp op0 held", address_o, 64'h4000);
    set_op(64'h4000, 12'h008, 2'd2, 5'd12);
    tick();
    tick();
    chk("bp still op0", 64'(lsqId_o), 64'd10);
    ready_i = 1'b1;
    tick();
    chk("bp rel op1", 64'(lsqId_o), 64'd11);
    tick();
    chk("bp rel op2", 64'(lsqId_o), 64'd12);
    chk("bp rel op2 valid", 64'(valid_o), 64'd1);
    valid_i = 1'b0;
    tick();
    chk("bp empty", 64'(valid_o), 64'd0);

    // misalign counting only on delivery
    ready_i = 1'b0;
    set_op(64'h2004, 12'h000, 2'd3, 5'd4);
    tick();
    valid_i = 1'b0;
    chk("mis flag", 64'(misaligned_o), 64'd1);
    chk("mis cnt pre", 64'(misalignCnt_o), 64'd0);
    tick();
    chk("mis cnt held", 64'(misalignCnt_o), 64'd0);
    ready_i = 1'b1;
    tick();
    chk("mis cnt post", 64'(misalignCnt_o), 64'd1);
    set_op(64'h2003, 12'h000, 2'd0, 5'd5);
    tick();
    chk("byte never mis", 64'(misaligned_o), 64'd0);

    // wrap cases
    set_op(64'hFFFF_FFFF_FFFF_FFFF, 12'h001, 2'd0, 5'd6);
    tick();
    chk("wrap up", address_o, 64'h0);
    set_op(64'h0, 12'h800, 2'd0, 5'd7);
    tick();
    chk("wrap down", address_o, 64'hFFFF_FFFF_FFFF_F800);
    valid_i = 1'b0;
    tick();

    // flush while FULL with an incoming op
    ready_i = 1'b0;
    set_op(64'h3001, 12'h000, 2'd1, 5'd20);
    tick();
    set_op(64'h3003, 12'h000, 2'd1, 5'd21);
    tick();
    chk("pre-flush full", 64'(ready_o), 64'd0);
    cnt_before = misalignCnt_o;
    set_op(64'h3005, 12'h000, 2'd1, 5'd22);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("flush valid_o", 64'(valid_o), 64'd0);
    chk("flush ready_o", 64'(ready_o), 64'd1);
    chk("flush cnt", 64'(misalignCnt_o), 64'(cnt_before));
    ready_i = 1'b1;
    tick();
    tick();

    // randomized traffic, including flushes and mid-run resets
    for (int i = 0; i < 3000; i++) begin
      valid_i    = ($urandom_range(0, 3) != 0);
      ready_i    = ($urandom_range(0, 2) != 0);
      flush_i    = ($urandom_range(0, 31) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      src1_i     = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                               : {32'($urandom), 32'($urandom)};
      imm_i      = 12'($urandom);
      ldstSize_i = 2'($urandom);
      isLoad_i   = 1'($urandom);
      lsqId_i    = 5'($urandom);
      phyDest_i  = 7'($urandom);
      tick();
    end
    reset = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();

    // counter saturation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_op(64'h1, 12'h000, 2'd1, 5'd9);
    n = 0;
    while (m_cnt != 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    chk("sat reached in budget", 64'(n < 70000), 64'd1);
    chk("sat cnt", 64'(misalignCnt_o), 64'hFFFF);
    tick();
    tick();
    chk("sat cnt stays", 64'(misalignCnt_o), 64'hFFFF);
    valid_i = 1'b0;
    reset = 1'b1;
    tick();
    chk("sat reset cnt", 64'(misalignCnt_o), 64'd0);
    chk("sat reset ready", 64'(ready_o), 64'd1);
    chk("sat reset valid", 64'(valid_o), 64'd0);
    reset = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
